// File: rtl/trp_ctrl_if.sv
// Valid/ready stream bundle carrying one row or beat of the transpose buffer.
interface trp_ctrl_if #(
    parameter int W = 512
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trp_ctrl.sv
// Transpose buffer sequencer: fills trp_fifo with a frame of rows, then
// drains transposed beats through a 2-entry queue sized for 1-cycle read latency.
module trp_ctrl #(
    parameter int BUFFD = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    trp_ctrl_if.slave          in_s,
    trp_ctrl_if.master         out_s,
    output logic               out_last,
    output logic               busy,
    output logic               err,
    output logic               ffinit,
    output logic               ffwreq,
    output logic               ffrreq,
    output logic [1:0]         ffmode,
    output logic [BUFFD*8-1:0] ffwdata,
    input  logic [BUFFD*8-1:0] ffrdata,
    input  logic               ffrvld
);
    localparam int AW = $clog2(BUFFD);
    localparam int W  = BUFFD * 8;

    typedef logic [AW:0] cnt_t;

    localparam cnt_t FULL = cnt_t'(BUFFD);
    localparam cnt_t QTR  = cnt_t'(BUFFD / 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    cnt_t         wcnt_q, wcnt_d;
    cnt_t         iss_q, iss_d;
    logic         infl_q, infl_d;
    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] q0_data_q, q0_data_d;
    logic [W-1:0] q1_data_q, q1_data_d;
    logic         q0_last_q, q0_last_d;
    logic         q1_last_q, q1_last_d;

    logic         legal;
    logic         pop;
    logic         push;
    logic         last_in;
    logic [1:0]   slot;
    cnt_t         target;

    assign legal   = (mode == 2'b01) || (mode == 2'b10);
    assign target  = (mode_q == 2'b10) ? QTR : FULL;

    assign out_s.valid = occ_q != 2'd0;
    assign out_s.data  = q0_data_q;
    assign out_last    = q0_last_q;

    assign pop     = out_s.valid && out_s.ready;
    assign push    = ffrvld && infl_q;
    assign last_in = iss_q == target;
    assign slot    = occ_q - {1'b0, pop};

    assign busy       = state_q != S_IDLE;
    assign err        = (state_q == S_IDLE) && in_s.valid && !legal;
    assign in_s.ready = state_q == S_FILL;
    assign ffwreq     = in_s.ready && in_s.valid;
    assign ffwdata    = in_s.data;
    assign ffinit     = state_q == S_INIT;
    assign ffmode     = mode_q;

    // A read is only issued when the queue has a free slot for its data
    // once every read already in flight has landed.
    assign ffrreq = (state_q == S_DRAIN) && (iss_q < target) &&
                    (({1'b0, occ_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wcnt_d  = wcnt_q;
        iss_d   = iss_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_s.valid && legal) begin
                    state_d = S_INIT;
                    mode_d  = mode;
                end
            end
            S_INIT: begin
                wcnt_d  = '0;
                iss_d   = '0;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (ffwreq) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == FULL - 1'b1) state_d = S_DRAIN;
                end
            end
            default: begin
                if (ffrreq) iss_d = iss_q + 1'b1;
                if (pop && q0_last_q) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        infl_d    = ffrreq;
        occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
        q0_data_d = q0_data_q;
        q0_last_d = q0_last_q;
        q1_data_d = q1_data_q;
        q1_last_d = q1_last_q;
        if (pop) begin
            q0_data_d = q1_data_q;
            q0_last_d = q1_last_q;
            q1_last_d = 1'b0;
        end
        if (push) begin
            if (slot == 2'd0) begin
                q0_data_d = ffrdata;
                q0_last_d = last_in;
            end else begin
                q1_data_d = ffrdata;
                q1_last_d = last_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b01;
            wcnt_q    <= '0;
            iss_q     <= '0;
            infl_q    <= 1'b0;
            occ_q     <= 2'd0;
            q0_data_q <= '0;
            q1_data_q <= '0;
            q0_last_q <= 1'b0;
            q1_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wcnt_q    <= wcnt_d;
            iss_q     <= iss_d;
            infl_q    <= infl_d;
            occ_q     <= occ_d;
            q0_data_q <= q0_data_d;
            q1_data_q <= q1_data_d;
            q0_last_q <= q0_last_d;
            q1_last_q <= q1_last_d;
        end
    end
endmodule

// File: doc/trp_ctrl.md
# trp_ctrl

Sequencing controller for the transpose buffer (`trp_fifo`). It accepts a frame of BUFFD row vectors on a valid/ready input stream and writes them into the buffer. It then drains the transposed columns from the buffer onto a valid/ready output stream, with a 2-entry output queue that absorbs the buffer's fixed 1-cycle read latency under backpressure. It sits directly upstream and downstream of `trp_fifo`, owning all of that block's control inputs.

## Interface
- BUFFD, 64, vector width in bytes and frame depth in rows; power of two, ≥8.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- mode  in  2  frame mode: 2'b01 = 8-bit, 2'b10 = 32-bit, others illegal; sampled only when leaving IDLE.
- in_valid / in_ready  in / out  1 / 1  input row handshake.
- in_data  in  BUFFD*8  input row.
- out_valid / out_ready  out / in  1 / 1  output beat handshake.
- out_data  out  BUFFD*8  transposed beat.
- out_last  out  1  marks the final beat of the frame.
- busy  out  1  high in any state other than IDLE.
- err  out  1  illegal-mode indication.
- ffinit, ffwreq, ffrreq  out  1 each  buffer controls.
- ffmode  out  2  latched mode driven to the buffer.
- ffwdata  out  BUFFD*8  buffer write data; equals in_data combinationally.
- ffrdata  in  BUFFD*8  buffer read data.
- ffrvld  in  1  buffer read valid.

## Operation
- FSM states:
  - IDLE → INIT when in_valid and mode is legal; mode is latched into ffmode on that edge.
  - INIT: ffinit=1 for exactly 1 cycle; in_ready=0; → FILL.
  - FILL: in_ready=1. ffwreq = in_valid. Write counter wcnt (log2(BUFFD)+1 bits) increments on each accepted row. After the BUFFD-th accepted row → DRAIN. Gaps in in_valid are allowed.
  - DRAIN: in_ready=0.
    - Read target is BUFFD beats in 8-bit mode and BUFFD/4 beats in 32-bit mode.
    - ffrreq = (issued < target) && (occ + inflight − pop < 2), where:
      - occ = output queue occupancy, 0..2;
      - inflight = ffrreq registered from the previous cycle;
      - pop = out_valid && out_ready.
    - Each ffrvld pushes ffrdata into the queue. The beat that corresponds to the final issued read carries a last flag.
    - → IDLE on the cycle the last beat pops, i.e. issued == target, queue empty, inflight 0.
- Illegal mode: err = IDLE && in_valid && mode∉{01,10}, combinational. The FSM stays in IDLE, in_ready stays 0, ffinit is not asserted, and the row is not consumed.
- in_ready is 0 in IDLE, INIT and DRAIN. Upstream holds the next frame until FILL.
- Output queue:
  - out_valid = occ > 0.
  - out_data and out_last come from the head entry, which is a register.
  - A push and a pop in the same cycle are legal. Overflow is impossible by construction of the credit rule.
- An unexpected ffrvld with no read in flight is ignored and not pushed.
- Reset values: FSM in IDLE; all counters 0; queue empty; out_valid=0, out_last=0, out_data=0, in_ready=0, busy=0, err=0, ffinit=0, ffwreq=0, ffrreq=0, ffmode=2'b01.
- Reset mid-operation discards the partial frame. The next frame starts with ffinit.

## Timing
- in_valid rising in IDLE (edge t0) → INIT during cycle t0+1 → in_ready=1 from cycle t0+2.
- Write path: ffwreq and ffwdata are combinational from the input, so the buffer captures the row on the same edge as the input handshake.
- Read latency: ffrreq in cycle t → ffrvld in t+1 → queue push at end of t+1 → out_valid in t+2.
- With out_ready held at 1, one ffrreq is issued per cycle and output runs at 1 beat per cycle after the first.
- Frame time with no stalls is 2 + BUFFD + target + 2 cycles, from IDLE exit to return to IDLE.
- busy falls in the cycle after the out_last pop.

## Test plan
- BUFFD=8, mode 01, row r byte j = 16r+j, no stalls:
  - 8 beats; beat k byte i = 16i+k;
  - out_last on beat 7 only;
  - exactly 8 ffwreq and 8 ffrreq;
  - ffinit once.
- BUFFD=8, mode 10, same rows:
  - 2 beats; beat k byte i = 16(i/4) + 4k + i%4;
  - out_last on beat 1.
- BUFFD=64, mode 01, out_ready random 30% low, in_valid random gaps:
  - the 64 beats match the transpose with no loss and no duplication;
  - assert occ + inflight ≤ 2 every cycle.
- mode 2'b11 with in_valid=1 for 5 cycles:
  - err=1 each cycle, in_ready=0, ffinit=0, busy=0;
  - mode then set to 01 → INIT next cycle.
- Reset asserted after 3 beats popped in DRAIN:
  - all outputs take their reset values immediately;
  - the following full frame is output correctly, starting with an ffinit pulse.
- Two frames with in_valid held high:
  - in_ready=0 throughout DRAIN;
  - the second frame's ffinit occurs exactly 1 cycle after the first frame's busy falls;
  - both frames are output correctly.
